// File: rtl/instr_loader_if.sv
// rtl/instr_loader_if.sv - control, byte-stream and instruction-memory write bundle for instr_loader
interface instr_loader_if #(
  parameter int ADDR_W = 7,
  parameter int CNT_W  = 8
);
  logic              start;
  logic [CNT_W-1:0]  num_words;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic              cpu_hlt;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, num_words, byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_din, cpu_hlt, busy, done, err
  );

  modport slave (
    input  start, num_words, byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_din, cpu_hlt, busy, done, err
  );
endinterface

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - byte-stream program loader writing big-endian words into instruction memory
module instr_loader #(
  parameter int ADDR_W = 7,
  parameter int CNT_W  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_loader_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  nwords_q, nwords_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [23:0]       shift_q, shift_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       din_q, din_d;
  logic              we_q, we_d;
  logic              rdy_q, rdy_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              hlt_q, hlt_d;
  logic              start_ok;
  logic              byte_acc;
  logic              last_word;

  // Legal length is 1..DEPTH; rdy_q is only ever high in RECV so it gates acceptance.
  assign start_ok  = (bus.num_words != '0) && (bus.num_words <= CNT_W'(DEPTH));
  assign byte_acc  = bus.byte_valid & rdy_q;
  assign last_word = (CNT_W'(addr_q) == (nwords_q - CNT_W'(1)));

  // Next-state logic; all outputs are registered and derived from the next state.
  always_comb begin
    state_d  = state_q;
    nwords_d = nwords_q;
    bcnt_d   = bcnt_q;
    shift_d  = shift_q;
    addr_d   = addr_q;
    din_d    = din_q;
    hlt_d    = hlt_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (start_ok) begin
            nwords_d = bus.num_words;
            bcnt_d   = 2'd0;
            addr_d   = '0;
            hlt_d    = 1'b1;
            state_d  = RECV;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RECV: begin
        if (byte_acc) begin
          shift_d = {shift_q[15:0], bus.byte_data};
          bcnt_d  = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            din_d   = {shift_q, bus.byte_data};
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        if (last_word) begin
          hlt_d   = 1'b0;
          state_d = DONE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = RECV;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    rdy_d  = (state_d == RECV);
    we_d   = (state_d == WRITE);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and output registers; reset discards any partial word but leaves memory alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      nwords_q <= '0;
      bcnt_q   <= 2'd0;
      shift_q  <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      we_q     <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      hlt_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      nwords_q <= nwords_d;
      bcnt_q   <= bcnt_d;
      shift_q  <= shift_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      we_q     <= we_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      hlt_q    <= hlt_d;
    end
  end

  assign bus.byte_ready = rdy_q;
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_din    = din_q;
  assign bus.cpu_hlt    = hlt_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - directed self-checking bench for instr_loader
module tb_instr_loader;
  localparam int ADDR_W = 7;
  localparam int CNT_W  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_loader_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();
  instr_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int we_cnt = 0, done_cnt = 0, err_cnt = 0, rdy_low_cnt = 0, hlt_bad = 0;
  int last_we_cyc = 0, done_cyc = 0;
  logic done_hlt = 1'b1;
  logic [ADDR_W-1:0] log_addr [512];
  logic [31:0]       log_din  [512];
  logic [7:0]        stim     [512];
  int gaps [5] = '{3, 0, 1, 2, 1};

  always @(posedge clk) cyc++;

  // Passive monitor sampling outputs mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_we && we_cnt < 512) begin
        log_addr[we_cnt] = bus.mem_addr;
        log_din[we_cnt]  = bus.mem_din;
        last_we_cyc = cyc;
        we_cnt++;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
        done_hlt = bus.cpu_hlt;
      end
      if (bus.err) err_cnt++;
      if (bus.busy && !bus.byte_ready && !bus.done) rdy_low_cnt++;
      if (bus.busy && !bus.done && !bus.cpu_hlt) hlt_bad++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {bus.cpu_hlt, bus.busy, bus.done, bus.err, bus.mem_we, bus.byte_ready};
  endfunction

  task automatic drive_start(input logic [CNT_W-1:0] n);
    bus.num_words = n;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Present a byte after gap idle cycles and hold it until it is taken.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    if (gap > 0) begin
      bus.byte_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    bus.byte_valid = 1'b1;
    bus.byte_data = b;
    n = 0;
    while (!bus.byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_timeout", 32'(bus.byte_ready), 32'd1);
    @(negedge clk);
  endtask

  task automatic load(input int n, input bit gapped);
    for (int i = 0; i < 4 * n; i++) send_byte(stim[i], gapped ? gaps[i % 5] : 0);
    bus.byte_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check("idle_timeout", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int w0, d0, e0, r0, h0, sc, bad;
    logic [7:0] iv;
    logic [31:0] ew;
    bus.start = 1'b0;
    bus.num_words = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_outs", 32'(outs()), 32'b100000);
    check("rst_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_din", bus.mem_din, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Illegal lengths right after reset: cpu_hlt stays 1.
    drive_start(8'd0);
    check("err0_outs", 32'(outs()), 32'b100100);
    @(negedge clk);
    check("err0_clear", 32'(bus.err), 32'd0);
    drive_start(8'd129);
    check("err129_outs", 32'(outs()), 32'b100100);
    @(negedge clk);
    check("err_no_we", 32'(we_cnt), 32'd0);

    // Reset mid-word after two bytes.
    drive_start(8'd1);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_outs", 32'(outs()), 32'b100000);
    check("midrst_addr", {bus.mem_din[31:7], bus.mem_addr}, 32'd0);
    bus.byte_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // One word after reset; the partial AA BB must not leak in.
    stim[0] = 8'h11; stim[1] = 8'h22; stim[2] = 8'h33; stim[3] = 8'h44;
    w0 = we_cnt; d0 = done_cnt;
    drive_start(8'd1);
    load(1, 0);
    wait_idle();
    check("w1_count", 32'(we_cnt - w0), 32'd1);
    check("w1_addr", 32'(log_addr[w0]), 32'd0);
    check("w1_din", log_din[w0], 32'h11223344);
    check("w1_done", 32'(done_cnt - d0), 32'd1);
    check("w1_done_hlt", 32'(done_hlt), 32'd0);
    check("w1_hlt_after", 32'(bus.cpu_hlt), 32'd0);

    // Three words at full rate.
    for (int i = 0; i < 12; i++) stim[i] = 8'(i);
    w0 = we_cnt; d0 = done_cnt; r0 = rdy_low_cnt; h0 = hlt_bad;
    sc = cyc;
    drive_start(8'd3);
    check("w3_start_outs", 32'(outs()), 32'b110001);
    load(3, 0);
    wait_idle();
    check("w3_cycles", 32'(cyc - sc), 32'd17);
    check("w3_count", 32'(we_cnt - w0), 32'd3);
    check("w3_d0", log_din[w0], 32'h00010203);
    check("w3_d1", log_din[w0 + 1], 32'h04050607);
    check("w3_d2", log_din[w0 + 2], 32'h08090A0B);
    check("w3_a2", 32'(log_addr[w0 + 2]), 32'd2);
    check("w3_rdy_low", 32'(rdy_low_cnt - r0), 32'd3);
    check("w3_done_lat", 32'(done_cyc - last_we_cyc), 32'd1);
    check("w3_hlt_held", 32'(hlt_bad - h0), 32'd0);

    // Same three words with idle gaps between bytes.
    w0 = we_cnt;
    drive_start(8'd3);
    load(3, 1);
    wait_idle();
    check("gap_count", 32'(we_cnt - w0), 32'd3);
    check("gap_d0", log_din[w0], 32'h00010203);
    check("gap_d1", log_din[w0 + 1], 32'h04050607);
    check("gap_d2", log_din[w0 + 2], 32'h08090A0B);

    // Illegal start after a load leaves cpu_hlt released.
    drive_start(8'd0);
    check("err_post_outs", 32'(outs()), 32'b000100);

    // Full depth: 128 words, no wrap.
    for (int i = 0; i < 128; i++) begin
      iv = 8'(i);
      stim[4*i] = iv; stim[4*i+1] = 8'h5A; stim[4*i+2] = ~iv; stim[4*i+3] = 8'hC3;
    end
    w0 = we_cnt; d0 = done_cnt;
    drive_start(8'd128);
    load(128, 0);
    wait_idle();
    check("w128_count", 32'(we_cnt - w0), 32'd128);
    check("w128_first", log_din[w0], 32'h005AFFC3);
    check("w128_last_addr", 32'(log_addr[w0 + 127]), 32'h7F);
    check("w128_last_din", log_din[w0 + 127], 32'h7F5A80C3);
    check("w128_done", 32'(done_cnt - d0), 32'd1);
    check("w128_done_lat", 32'(done_cyc - last_we_cyc), 32'd1);
    bad = 0;
    for (int i = 0; i < 128; i++) begin
      iv = 8'(i);
      ew = {iv, 8'h5A, ~iv, 8'hC3};
      if (32'(log_addr[w0 + i]) != i || log_din[w0 + i] !== ew) bad++;
    end
    check("w128_seq", 32'(bad), 32'd0);

    // Reload re-halts the CPU; start pulses mid-load are ignored.
    stim[0] = 8'hDE; stim[1] = 8'hAD; stim[2] = 8'hBE; stim[3] = 8'hEF;
    stim[4] = 8'h01; stim[5] = 8'h02; stim[6] = 8'h03; stim[7] = 8'h04;
    w0 = we_cnt; e0 = err_cnt;
    drive_start(8'd2);
    check("reload_outs", 32'(outs()), 32'b110001);
    send_byte(stim[0], 0);
    send_byte(stim[1], 0);
    bus.byte_valid = 1'b0;
    drive_start(8'd1);
    drive_start(8'd0);
    for (int i = 2; i < 8; i++) send_byte(stim[i], 0);
    bus.byte_valid = 1'b0;
    wait_idle();
    check("ign_count", 32'(we_cnt - w0), 32'd2);
    check("ign_a0", 32'(log_addr[w0]), 32'd0);
    check("ign_d0", log_din[w0], 32'hDEADBEEF);
    check("ign_d1", log_din[w0 + 1], 32'h01020304);
    check("ign_no_err", 32'(err_cnt - e0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_loader.md
# instr_loader

Program loader that fills the instruction memory over a byte-stream handshake, the write-side counterpart of the instruction fetch path. It accepts a word count, assembles incoming bytes into 32-bit big-endian instruction words and writes them to consecutive instruction-memory addresses starting at 0. It holds the CPU halted from reset until a load completes, and again during any later load.

## Interface
Parameters:
- ADDR_W, 7, instruction-memory address width (DEPTH = 2^ADDR_W = 128 words)
- CNT_W, 8, width of num_words (must hold DEPTH)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle load request; sampled only in IDLE
- num_words  in  CNT_W  words to load; legal range 1..DEPTH
- byte_valid  in  1  byte_data is valid this cycle
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts a byte this cycle
- mem_we  out  1  instruction-memory write enable (one cycle per word)
- mem_addr  out  ADDR_W  write address
- mem_din  out  32  write data
- cpu_hlt  out  1  holds CPU fetch in halt
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse, load complete
- err  out  1  one-cycle pulse, start with illegal num_words

## Operation
- States: IDLE, RECV, WRITE, DONE. All outputs registered.
- IDLE: byte_ready=0. On start with 1 <= num_words <= DEPTH: latch num_words, clear word counter, byte counter and mem_addr to 0, set cpu_hlt=1, go RECV. On start with num_words=0 or >DEPTH: pulse err next cycle, stay IDLE, cpu_hlt unchanged.
- RECV: byte_ready=1. Byte accepted when byte_valid & byte_ready at a rising edge. Bytes shift in MSB first: word = {b0,b1,b2,b3}. Byte counter 0..3; on the 4th accepted byte go WRITE.
- WRITE (one cycle): mem_we=1, mem_din=assembled word, mem_addr=current word index; byte_ready=0. Next: if word index == num_words-1 go DONE, else increment mem_addr and go RECV.
- DONE (one cycle): done=1, cpu_hlt=0, busy=1; next IDLE.
- start outside IDLE is ignored (no err).
- mem_addr never wraps: num_words <= DEPTH guarantees last address DEPTH-1.
- byte_valid while byte_ready=0 is ignored; the source must hold the byte (standard valid/ready, no drop).
- Reset (any time, including mid-word or mid-load): state IDLE, partial word discarded, counters 0, mem_addr=0, mem_din=0, mem_we=0, byte_ready=0, busy=0, done=0, err=0, cpu_hlt=1. Memory contents are not cleared.

## Timing
- Byte acceptance to mem_we: 4th byte accepted at edge N, mem_we high in cycle N..N+1 (the cycle after the edge), exactly one cycle.
- byte_ready low for exactly the one WRITE cycle per word; minimum 5 cycles per word at full stream rate.
- start at edge S (legal): busy=1, cpu_hlt=1, byte_ready=1 from edge S.
- Last word write at cycle W: done=1 and cpu_hlt=0 in cycle W+1; busy=0 in W+2.
- Total load time at full rate for n words: 1 + 5n + 1 cycles from start to IDLE.
- err pulses in the cycle after the illegal start edge.
- cpu_hlt=1 continuously from reset release until the first DONE.

## Test plan
- Reset: assert rst_n=0 mid-RECV after 2 bytes -> all outputs at reset values immediately; after release, load 1 word 11 22 33 44 -> mem_we once, addr 0, din 32'h11223344, done, cpu_hlt=0.
- Full-rate 3-word load (bytes 00..0B) -> writes 32'h00010203@0, 32'h04050607@1, 32'h08090A0B@2; byte_ready low exactly the 3 WRITE cycles; done 1 cycle after 3rd write; 17 cycles start-to-IDLE.
- Gapped valid (random 0-3 idle cycles between bytes) and valid held during WRITE -> identical memory image, no byte lost or duplicated.
- num_words=0 and num_words=129 -> err pulse each, no mem_we, busy stays 0, cpu_hlt stays 1.
- num_words=128 -> last write at addr 7'h7F, no wrap, done after 128th write.
- start pulsed during RECV -> ignored, load continues unchanged; second start after done -> cpu_hlt returns to 1, reload from addr 0.
